// File: rtl/lc3_memaccess_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_memaccess_ctrl
//
// Data-memory access sequencer for the LC3 MemAccess stage. It takes one
// load/store request at a time (LD, LDI, ST, STI) and runs a variable-latency
// req/ack handshake to data memory. It then presents the result through a
// valid/ready response handshake. Indirect ops first read a pointer and then
// access the pointed-to location. An access phase that waits MAX_WAIT cycles
// without an ack is aborted and reported with rsp_err.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_op                00 LD, 01 LDI, 10 ST, 11 STI
//   req_addr, req_data    effective address and store data
//   DMem_req/DMem_ack     memory access handshake
//   DMem_addr/din/rd      memory address, write data, 1 = read
//   DMem_dout             memory read data, valid with DMem_ack
//   mem_state             0 read, 1 indirect read, 2 write, 3 idle
//   memout                last load result, held between responses
//   rsp_valid/rsp_ready   response handshake
//   rsp_err               response is a timeout abort
//
// ADDR_W must not exceed DATA_W, because the indirect pointer is taken from
// the low ADDR_W bits of the read data.
// ---------------------------------------------------------------------------
module lc3_memaccess_ctrl #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              DMem_req,
   input  logic              DMem_ack,
   output logic [ADDR_W-1:0] DMem_addr,
   output logic [DATA_W-1:0] DMem_din,
   output logic              DMem_rd,
   input  logic [DATA_W-1:0] DMem_dout,
   output logic [1:0]        mem_state,
   output logic [DATA_W-1:0] memout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_err
);

   // The counter must be able to hold MAX_WAIT. It keeps one bit even when
   // the timeout is disabled, so the logic stays legal.
   localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IND,
      ST_RD,
      ST_WR,
      ST_RSP
   } state_t;

   state_t            state_q,     state_d;
   logic              store_q,     store_d;
   logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
   logic [DATA_W-1:0] dmem_din_q,  dmem_din_d;
   logic [DATA_W-1:0] memout_q,    memout_d;
   logic              rsp_err_q,   rsp_err_d;
   logic [CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;
   logic              timeout_hit;

   // The limit applies only to a cycle without an ack. An ack on the limit
   // cycle is handled first in every access state, so the ack wins.
   assign timeout_hit = (MAX_WAIT != 0) && (wait_cnt_q == CNT_MAX);

   // Next-state logic. Every register holds unless a transition updates it.
   // The wait counter restarts on every entry into an access phase, so each
   // pointer read and each data access gets its own MAX_WAIT budget.
   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      dmem_addr_d = dmem_addr_q;
      dmem_din_d  = dmem_din_q;
      memout_d    = memout_q;
      rsp_err_d   = rsp_err_q;
      wait_cnt_d  = wait_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               store_d     = req_op[1];
               dmem_addr_d = req_addr;
               if (req_op[1]) begin
                  dmem_din_d = req_data;
               end
               wait_cnt_d = '0;
               if (req_op[0]) begin
                  state_d = ST_IND;
               end else if (req_op[1]) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end

         ST_IND: begin
            if (DMem_ack) begin
               dmem_addr_d = DMem_dout[ADDR_W-1:0];
               wait_cnt_d  = '0;
               state_d     = store_q ? ST_WR : ST_RD;
            end else if (timeout_hit) begin
               rsp_err_d = 1'b1;
               state_d   = ST_RSP;
            end else if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end

         ST_RD: begin
            if (DMem_ack) begin
               memout_d  = DMem_dout;
               rsp_err_d = 1'b0;
               state_d   = ST_RSP;
            end else if (timeout_hit) begin
               rsp_err_d = 1'b1;
               state_d   = ST_RSP;
            end else if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end

         ST_WR: begin
            if (DMem_ack) begin
               rsp_err_d = 1'b0;
               state_d   = ST_RSP;
            end else if (timeout_hit) begin
               rsp_err_d = 1'b1;
               state_d   = ST_RSP;
            end else if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end

         ST_RSP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset abandons any access in flight at
   // once and produces no response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         store_q     <= 1'b0;
         dmem_addr_q <= '0;
         dmem_din_q  <= '0;
         memout_q    <= '0;
         rsp_err_q   <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         store_q     <= store_d;
         dmem_addr_q <= dmem_addr_d;
         dmem_din_q  <= dmem_din_d;
         memout_q    <= memout_d;
         rsp_err_q   <= rsp_err_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   // Handshake outputs are decoded from the state register. DMem_req stays
   // high from the pointer phase into the data phase of an indirect access.
   always_comb begin
      req_ready = 1'b0;
      DMem_req  = 1'b0;
      DMem_rd   = 1'b0;
      rsp_valid = 1'b0;
      mem_state = 2'd3;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
         end
         ST_IND: begin
            DMem_req  = 1'b1;
            DMem_rd   = 1'b1;
            mem_state = 2'd1;
         end
         ST_RD: begin
            DMem_req  = 1'b1;
            DMem_rd   = 1'b1;
            mem_state = 2'd0;
         end
         ST_WR: begin
            DMem_req  = 1'b1;
            mem_state = 2'd2;
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
         end
         default: begin
            mem_state = 2'd3;
         end
      endcase
   end

   assign DMem_addr = dmem_addr_q;
   assign DMem_din  = dmem_din_q;
   assign memout    = memout_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lc3_memaccess_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lc3_memaccess_ctrl
//
// Self-checking bench for lc3_memaccess_ctrl. The bench acts as the data
// memory through a responder memory that the DUT's writes update. A separate
// reference memory follows the op semantics. Directed transactions come from a
// vector table. Hand-written sequences cover timeout, ack on the limit cycle,
// and reset during an access. A final run issues back-to-back ops with random
// wait states. All outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lc3_memaccess_ctrl;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 16;
   localparam int MAX_WAIT = 15;

   localparam logic [1:0] OP_LD  = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_ST  = 2'b10;
   localparam logic [1:0] OP_STI = 2'b11;

   typedef struct packed {
      logic [1:0]  op;
      logic [15:0] addr;
      logic [15:0] data;
      int          wait_a;
      int          wait_b;
      int          rsp_hold;
      logic [15:0] exp_memout;
      logic        exp_err;
   } vec_t;

   logic              clock = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic              DMem_req;
   logic              DMem_ack;
   logic [ADDR_W-1:0] DMem_addr;
   logic [DATA_W-1:0] DMem_din;
   logic              DMem_rd;
   logic [DATA_W-1:0] DMem_dout;
   logic [1:0]        mem_state;
   logic [DATA_W-1:0] memout;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_err;

   int assertions_evaluated = 0;
   int failures = 0;

   logic [15:0] dut_mem [logic [15:0]];
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] last_memout;
   logic [15:0] addr_pool [6];
   vec_t        vecs [6];
   vec_t        rv;
   logic [15:0] r_eff;

   lc3_memaccess_ctrl #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .DMem_req  (DMem_req),
      .DMem_ack  (DMem_ack),
      .DMem_addr (DMem_addr),
      .DMem_din  (DMem_din),
      .DMem_rd   (DMem_rd),
      .DMem_dout (DMem_dout),
      .mem_state (mem_state),
      .memout    (memout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_err   (rsp_err)
   );

   // Free-running clock: rising edges at 5, 15, 25, ... and falling edges on
   // multiples of 10.
   always #5 clock = ~clock;

   // The run is a fixed number of cycles, so this limit only trips if the
   // run itself goes wrong.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [15:0] dut_rd(input logic [15:0] a);
      if (dut_mem.exists(a)) return dut_mem[a];
      return 16'h0000;
   endfunction

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 16'h0000;
   endfunction

   // Compares one value and counts it. A mismatch prints one FAIL line.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertions_evaluated++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Runs one complete transaction from the idle state. The bench answers
   // each access phase after the number of wait cycles in the record, then
   // holds rsp_ready low for rsp_hold cycles. The pointer used by indirect
   // ops and the store target come from the reference memory.
   task automatic applyStimulus(input vec_t v);
      logic [15:0] ptr;
      logic [15:0] eff;
      logic [15:0] exp_addr;
      logic [1:0]  exp_ms;
      int          n_phases;
      int          w;
      ptr      = ref_rd(v.addr);
      eff      = v.op[0] ? ptr : v.addr;
      n_phases = v.op[0] ? 2 : 1;

      checkOutput("req_ready idle", 32'(req_ready), 32'd1);
      checkOutput("mem_state idle", 32'(mem_state), 32'd3);
      req_valid = 1'b1;
      req_op    = v.op;
      req_addr  = v.addr;
      req_data  = v.data;
      @(negedge clock);
      req_valid = 1'b0;
      req_addr  = 16'($urandom);
      req_data  = 16'($urandom);

      for (int p = 0; p < n_phases; p++) begin
         w        = (p == 0) ? v.wait_a : v.wait_b;
         exp_addr = (p == 0) ? v.addr : ptr;
         if (p < n_phases - 1) exp_ms = 2'd1;
         else                  exp_ms = v.op[1] ? 2'd2 : 2'd0;
         for (int k = 0; k <= w; k++) begin
            checkOutput("DMem_req access", 32'(DMem_req), 32'd1);
            checkOutput("mem_state access", 32'(mem_state), 32'(exp_ms));
            checkOutput("DMem_rd access", 32'(DMem_rd), 32'(exp_ms != 2'd2));
            checkOutput("DMem_addr access", 32'(DMem_addr), 32'(exp_addr));
            if (exp_ms == 2'd2) checkOutput("DMem_din write", 32'(DMem_din), 32'(v.data));
            checkOutput("rsp_valid busy", 32'(rsp_valid), 32'd0);
            checkOutput("req_ready busy", 32'(req_ready), 32'd0);
            checkOutput("memout busy", 32'(memout), 32'(last_memout));
            if (k == w) begin
               DMem_ack = 1'b1;
               if (exp_ms == 2'd2) begin
                  dut_mem[DMem_addr] = DMem_din;
                  DMem_dout = 16'($urandom);
               end else begin
                  DMem_dout = dut_rd(DMem_addr);
               end
            end else begin
               DMem_ack  = 1'b0;
               DMem_dout = 16'($urandom);
            end
            @(negedge clock);
         end
      end
      DMem_ack  = 1'b0;
      DMem_dout = 16'($urandom);

      for (int r = 0; r <= v.rsp_hold; r++) begin
         checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("rsp_err", 32'(rsp_err), 32'(v.exp_err));
         checkOutput("memout", 32'(memout), 32'(v.exp_memout));
         checkOutput("DMem_req rsp", 32'(DMem_req), 32'd0);
         checkOutput("req_ready rsp", 32'(req_ready), 32'd0);
         checkOutput("mem_state rsp", 32'(mem_state), 32'd3);
         rsp_ready = (r == v.rsp_hold);
         @(negedge clock);
      end
      rsp_ready = 1'b0;
      checkOutput("rsp_valid after", 32'(rsp_valid), 32'd0);
      checkOutput("req_ready after", 32'(req_ready), 32'd1);

      if (v.op[1]) ref_mem[eff] = v.data;
      last_memout = v.exp_memout;
   endtask

   // Issues a store to 0x6000 and leaves the ack low until the limit cycle.
   // The ack is raised on that cycle only when ack_on_limit is set.
   task automatic runTimeout(input bit ack_on_limit);
      checkOutput("req_ready idle to", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = OP_ST;
      req_addr  = 16'h6000;
      req_data  = 16'hCAFE;
      @(negedge clock);
      req_valid = 1'b0;
      for (int k = 0; k <= MAX_WAIT; k++) begin
         checkOutput("DMem_req to", 32'(DMem_req), 32'd1);
         checkOutput("mem_state to", 32'(mem_state), 32'd2);
         checkOutput("rsp_valid to", 32'(rsp_valid), 32'd0);
         if (k == MAX_WAIT && ack_on_limit) begin
            DMem_ack = 1'b1;
            dut_mem[DMem_addr] = DMem_din;
         end else begin
            DMem_ack = 1'b0;
         end
         @(negedge clock);
      end
      DMem_ack = 1'b0;
      if (ack_on_limit) ref_mem[16'h6000] = 16'hCAFE;
      checkOutput("rsp_valid to end", 32'(rsp_valid), 32'd1);
      checkOutput("rsp_err to end", 32'(rsp_err), ack_on_limit ? 32'd0 : 32'd1);
      checkOutput("DMem_req to end", 32'(DMem_req), 32'd0);
      checkOutput("memout to end", 32'(memout), 32'(last_memout));
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      checkOutput("req_ready to idle", 32'(req_ready), 32'd1);
      checkOutput("mem_state to idle", 32'(mem_state), 32'd3);
   endtask

   // Main sequence: reset, the directed table, timeout cases, reset during
   // a read, random back-to-back traffic, then a final memory compare.
   initial begin
      reset     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_addr  = '0;
      req_data  = '0;
      DMem_ack  = 1'b0;
      DMem_dout = '0;
      rsp_ready = 1'b0;
      last_memout = 16'h0000;

      dut_mem[16'h3000] = 16'hBEEF;  ref_mem[16'h3000] = 16'hBEEF;
      dut_mem[16'h4000] = 16'h5000;  ref_mem[16'h4000] = 16'h5000;
      dut_mem[16'h0010] = 16'h0020;  ref_mem[16'h0010] = 16'h0020;
      dut_mem[16'h0020] = 16'hA5A5;  ref_mem[16'h0020] = 16'hA5A5;

      addr_pool = '{16'h0010, 16'h0020, 16'h3000, 16'h4000, 16'h5000, 16'h6000};

      //            op      addr      data      wA wB hold memout     err
      vecs[0] = '{OP_LD,  16'h3000, 16'h0000, 0, 0, 0, 16'hBEEF, 1'b0};
      vecs[1] = '{OP_STI, 16'h4000, 16'h1234, 3, 3, 0, 16'hBEEF, 1'b0};
      vecs[2] = '{OP_LDI, 16'h0010, 16'h0000, 0, 0, 4, 16'hA5A5, 1'b0};
      vecs[3] = '{OP_LD,  16'h5000, 16'h0000, 1, 0, 0, 16'h1234, 1'b0};
      vecs[4] = '{OP_ST,  16'h0020, 16'h7777, 2, 0, 1, 16'h1234, 1'b0};
      vecs[5] = '{OP_LDI, 16'h0010, 16'h0000, 2, 1, 0, 16'h7777, 1'b0};

      @(negedge clock);
      @(negedge clock);
      checkOutput("reset req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset DMem_req", 32'(DMem_req), 32'd0);
      checkOutput("reset DMem_rd", 32'(DMem_rd), 32'd0);
      checkOutput("reset DMem_addr", 32'(DMem_addr), 32'd0);
      checkOutput("reset DMem_din", 32'(DMem_din), 32'd0);
      checkOutput("reset mem_state", 32'(mem_state), 32'd3);
      checkOutput("reset memout", 32'(memout), 32'd0);
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b1;
      @(negedge clock);

      $display("[TB] directed vector table");
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      $display("[TB] ack timeout and ack on the limit cycle");
      runTimeout(1'b0);
      runTimeout(1'b1);

      $display("[TB] reset during a pending read");
      req_valid = 1'b1;
      req_op    = OP_LD;
      req_addr  = 16'h3000;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      checkOutput("DMem_req pending", 32'(DMem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("async DMem_req", 32'(DMem_req), 32'd0);
      checkOutput("async DMem_rd", 32'(DMem_rd), 32'd0);
      checkOutput("async DMem_addr", 32'(DMem_addr), 32'd0);
      checkOutput("async DMem_din", 32'(DMem_din), 32'd0);
      checkOutput("async mem_state", 32'(mem_state), 32'd3);
      checkOutput("async req_ready", 32'(req_ready), 32'd1);
      checkOutput("async memout", 32'(memout), 32'd0);
      checkOutput("async rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("async rsp_err", 32'(rsp_err), 32'd0);
      DMem_ack  = 1'b1;
      DMem_dout = 16'h9999;
      @(negedge clock);
      @(negedge clock);
      reset    = 1'b1;
      DMem_ack = 1'b0;
      @(negedge clock);
      checkOutput("post reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("post reset req_ready", 32'(req_ready), 32'd1);
      checkOutput("post reset memout", 32'(memout), 32'd0);
      last_memout = 16'h0000;
      applyStimulus('{OP_LD, 16'h3000, 16'h0000, 0, 0, 0, 16'hBEEF, 1'b0});

      $display("[TB] back-to-back random wait states");
      for (int i = 0; i < 12; i++) begin
         case (i % 4)
            0:       rv.op = OP_LD;
            1:       rv.op = OP_ST;
            2:       rv.op = OP_LDI;
            default: rv.op = OP_STI;
         endcase
         rv.addr     = addr_pool[$urandom_range(5, 0)];
         rv.data     = 16'($urandom);
         rv.wait_a   = int'($urandom_range(5, 0));
         rv.wait_b   = int'($urandom_range(5, 0));
         rv.rsp_hold = int'($urandom_range(2, 0));
         rv.exp_err  = 1'b0;
         r_eff       = rv.op[0] ? ref_rd(rv.addr) : rv.addr;
         rv.exp_memout = rv.op[1] ? last_memout : ref_rd(r_eff);
         applyStimulus(rv);
      end

      foreach (ref_mem[k]) begin
         checkOutput("memory contents", 32'(dut_rd(k)), 32'(ref_mem[k]));
      end
      foreach (dut_mem[k]) begin
         checkOutput("memory extra write", 32'(dut_mem[k]), 32'(ref_rd(k)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertions_evaluated, failures);
      $finish;
   end

endmodule
